// File: rtl/dram_controller.sv
// dram_controller -- fast-page controller for one 4M x 16 DRAM bank behind
// the system controller's DRAM select.
//
// Ports
//   CLK         40 MHz clock, all state on the rising edge
//   RST         synchronous reset, active low
//   AS/UDS/LDS  raw 68000 strobes (active low, asynchronous; synchronised here)
//   RW          1 = read, 0 = write (stable while AS is low, sampled directly)
//   DRAM        DRAM select from the system controller (active low, synchronised)
//   ADDR        CPU address A22..A1 (row = A22..A12, column = A11..A1)
//   MA          multiplexed row/column address
//   RAS/CASU/CASL/WE  DRAM strobes, active low
//   DTACK_DRAM  transfer acknowledge to the system controller, active low
//
// Optional build macro DRAM_SLOW_EN: stretches the CAS state to two cycles
// for slower (70 ns) parts.
//
// All DRAM pins are registered: the combinational block computes the next
// state together with the pin values that state should present, so a pin
// changes on the same edge the FSM enters the state that owns it.
module dram_controller #(
  parameter int REFRESH_INTERVAL = 600,
  parameter int RAS_PRECHARGE    = 3,
  parameter int REF_RAS_CYCLES   = 3,
  parameter int ROW_BITS         = 11
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                AS,
  input  logic                UDS,
  input  logic                LDS,
  input  logic                RW,
  input  logic                DRAM,
  input  logic [21:0]         ADDR,
  output logic [ROW_BITS-1:0] MA,
  output logic                RAS,
  output logic                CASU,
  output logic                CASL,
  output logic                WE,
  output logic                DTACK_DRAM
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ROW     = 3'd1;
  localparam logic [2:0] COL     = 3'd2;
  localparam logic [2:0] CAS     = 3'd3;
  localparam logic [2:0] ACK     = 3'd4;
  localparam logic [2:0] PRE     = 3'd5;
  localparam logic [2:0] REF_CAS = 3'd6;
  localparam logic [2:0] REF_RAS = 3'd7;

  localparam int RC_W = $clog2(REFRESH_INTERVAL);
  localparam logic [RC_W-1:0] REF_WRAP = RC_W'(REFRESH_INTERVAL - 1);

  // Shared down-counter for the multi-cycle states (PRE, REF_RAS, CAS).
  localparam int TW = 8;
  localparam logic [TW-1:0] PRE_LAST  = TW'(RAS_PRECHARGE - 1);
  localparam logic [TW-1:0] RREF_LAST = TW'(REF_RAS_CYCLES - 1);
`ifdef DRAM_SLOW_EN
  localparam logic [TW-1:0] CAS_LAST  = TW'(1);
`else
  localparam logic [TW-1:0] CAS_LAST  = TW'(0);
`endif

  logic [2:0]          state, state_n;
  logic [TW-1:0]       tmr, tmr_n;
  logic [RC_W-1:0]     ref_cnt;
  logic                ref_pend, pend_clr;
  logic [3:0]          sync1, sync2;   // {DRAM, LDS, UDS, AS}
  logic                as_s, uds_s, lds_s, dram_s;
  logic [ROW_BITS-1:0] row, col, ma_n;
  logic                ras_n, casu_n, casl_n, we_n, dtack_n, decide;

  assign as_s   = sync2[0];
  assign uds_s  = sync2[1];
  assign lds_s  = sync2[2];
  assign dram_s = sync2[3];

  assign row = ROW_BITS'(ADDR[21:11]);
  assign col = ROW_BITS'(ADDR[10:0]);

  always_comb begin
    state_n  = state;
    tmr_n    = tmr;
    ma_n     = MA;
    ras_n    = RAS;
    casu_n   = CASU;
    casl_n   = CASL;
    we_n     = WE;
    dtack_n  = 1'b1;   // only ever pulled low when the next state is ACK
    pend_clr = 1'b0;
    decide   = 1'b0;
    case (state)
      IDLE: decide = 1'b1;
      ROW: begin
        state_n = COL;
        ma_n    = col;
        we_n    = RW;   // WE settles a full cycle ahead of CAS
      end
      COL: begin
        if (!uds_s || !lds_s) begin
          state_n = CAS;
          casu_n  = uds_s;  // only strobed bytes get a CAS
          casl_n  = lds_s;
          tmr_n   = CAS_LAST;
        end else if (as_s) begin
          // aborted cycle: bus cycle ended before any data strobe
          state_n = PRE;
          ras_n   = 1'b1;
          we_n    = 1'b1;
          tmr_n   = PRE_LAST;
        end
      end
      CAS: begin
        if (tmr == '0) begin
          state_n = ACK;
          dtack_n = 1'b0;
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      ACK: begin
        if (as_s) begin
          state_n = PRE;
          ras_n   = 1'b1;
          casu_n  = 1'b1;
          casl_n  = 1'b1;
          we_n    = 1'b1;
          tmr_n   = PRE_LAST;
        end else begin
          dtack_n = 1'b0;
        end
      end
      // The last precharge cycle makes the IDLE decision itself, so a
      // waiting request starts exactly RAS_PRECHARGE cycles after RAS rose.
      PRE: begin
        if (tmr == '0) decide = 1'b1;
        else           tmr_n  = tmr - 1'b1;
      end
      REF_CAS: begin
        state_n = REF_RAS;
        ras_n   = 1'b0;
        tmr_n   = RREF_LAST;
      end
      REF_RAS: begin
        if (tmr == '0) begin
          state_n = PRE;
          ras_n   = 1'b1;
          casu_n  = 1'b1;
          casl_n  = 1'b1;
          tmr_n   = PRE_LAST;
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (decide) begin
      if (ref_pend) begin
        // CAS-before-RAS refresh wins over a simultaneous access
        state_n  = REF_CAS;
        pend_clr = 1'b1;
        casu_n   = 1'b0;
        casl_n   = 1'b0;
        ras_n    = 1'b1;
        we_n     = 1'b1;
      end else if (!as_s && !dram_s) begin
        state_n = ROW;
        ras_n   = 1'b0;
        ma_n    = row;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      tmr        <= '0;
      ref_cnt    <= '0;
      ref_pend   <= 1'b0;
      sync1      <= '1;
      sync2      <= '1;
      MA         <= '0;
      RAS        <= 1'b1;
      CASU       <= 1'b1;
      CASL       <= 1'b1;
      WE         <= 1'b1;
      DTACK_DRAM <= 1'b1;
    end else begin
      state      <= state_n;
      tmr        <= tmr_n;
      sync1      <= {DRAM, LDS, UDS, AS};
      sync2      <= sync1;
      MA         <= ma_n;
      RAS        <= ras_n;
      CASU       <= casu_n;
      CASL       <= casl_n;
      WE         <= we_n;
      DTACK_DRAM <= dtack_n;
      // A wrap that coincides with the consuming edge re-arms the flag;
      // a wrap while already pending just leaves it set.
      if (ref_cnt == REF_WRAP) begin
        ref_cnt  <= '0;
        ref_pend <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
        if (pend_clr) ref_pend <= 1'b0;
      end
    end
  end

  // CAS may only fall under an active RAS, except for CAS-before-RAS refresh.
  a_cas_under_ras: assert property (@(posedge CLK) disable iff (!RST)
    ($fell(CASU) || $fell(CASL)) |-> (!RAS || state == REF_CAS));

  // WE must be stable for as long as any CAS stays low.
  a_we_stable: assert property (@(posedge CLK) disable iff (!RST)
    ($past(!CASU || !CASL) && (!CASU || !CASL)) |-> $stable(WE));

endmodule

// File: tb/tb_dram_controller.sv
// tb_dram_controller -- scoreboard bench for dram_controller.
// Stimulus pushes the expected pin snapshots {RAS,CASU,CASL,WE,DTACK,MA}
// with the cycle they must appear on; a monitor pops one entry each time
// any DRAM pin changes and compares both the value and the cycle.
module tb_dram_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        AS = 1'b1, UDS = 1'b1, LDS = 1'b1, RW = 1'b1, DRAM = 1'b1;
  logic [21:0] ADDR = '0;
  logic [10:0] MA;
  logic        RAS, CASU, CASL, WE, DTACK_DRAM;

  dram_controller dut (
    .CLK(CLK), .RST(RST), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
    .DRAM(DRAM), .ADDR(ADDR), .MA(MA), .RAS(RAS), .CASU(CASU),
    .CASL(CASL), .WE(WE), .DTACK_DRAM(DTACK_DRAM)
  );

`ifdef DRAM_SLOW_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  int          t_q[$];
  logic [15:0] o_q[$];
  string       n_q[$];

  function automatic logic [15:0] ev(input logic r, cu, cl, w, d,
                                     input logic [10:0] ma);
    return {r, cu, cl, w, d, ma};
  endfunction

  task automatic push(input int t, input logic [15:0] o, input string nm);
    t_q.push_back(t);
    o_q.push_back(o);
    n_q.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: every pin change must match the next scheduled snapshot.
  bit          mon_on = 1'b0;
  logic [15:0] prev, cur;
  always @(negedge CLK) begin
    if (mon_on) begin
      cur = {RAS, CASU, CASL, WE, DTACK_DRAM, MA};
      if (cur !== prev) begin
        total++;
        if (t_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: got %h at cycle %0d, none due",
                   cur, cyc);
        end else begin
          if (cur !== o_q[0] || cyc != t_q[0]) begin
            bad++;
            $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                     n_q[0], cur, cyc, o_q[0], t_q[0]);
          end
          void'(t_q.pop_front());
          void'(o_q.pop_front());
          void'(n_q.pop_front());
        end
        prev = cur;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_dtack(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (DTACK_DRAM === 1'b0) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: DTACK_DRAM still high after 40 cycles", nm);
    end
  endtask

  int r, n, m, a, e0, r2;

  initial begin
    tick(3);
    chk("reset_RAS",   RAS,        1);
    chk("reset_CASU",  CASU,       1);
    chk("reset_CASL",  CASL,       1);
    chk("reset_WE",    WE,         1);
    chk("reset_DTACK", DTACK_DRAM, 1);
    chk("reset_MA",    MA,         0);
    prev   = {RAS, CASU, CASL, WE, DTACK_DRAM, MA};
    mon_on = 1'b1;
    RST    = 1'b1;
    r      = cyc;

    // Word read at byte 0x123456: row 0x123, column 0x22B.
    tick(2);
    n = cyc;
    ADDR = 22'h091A2B; RW = 1'b1; UDS = 1'b0; LDS = 1'b0; DRAM = 1'b0; AS = 1'b0;
    push(n + 3,     ev(0, 1, 1, 1, 1, 11'h123), "read_row");
    push(n + 4,     ev(0, 1, 1, 1, 1, 11'h22B), "read_col");
    push(n + 5,     ev(0, 0, 0, 1, 1, 11'h22B), "read_cas");
    push(n + 6 + S, ev(0, 0, 0, 1, 0, 11'h22B), "read_dtack");
    wait_dtack("read");
    m = cyc;
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1; DRAM = 1'b1;
    push(m + 3, ev(1, 1, 1, 1, 1, 11'h22B), "read_release");

    // Lower-byte write at byte 0x100001 requested during precharge:
    // RAS must stay high for the full 3 precharge cycles.
    tick(2);
    ADDR = 22'h080000; RW = 1'b0; UDS = 1'b1; LDS = 1'b0; DRAM = 1'b0; AS = 1'b0;
    push(m + 6,     ev(0, 1, 1, 1, 1, 11'h100), "pre_then_row");
    push(m + 7,     ev(0, 1, 1, 0, 1, 11'h000), "wr_col_we");
    push(m + 8,     ev(0, 1, 0, 0, 1, 11'h000), "wr_casl");
    push(m + 9 + S, ev(0, 1, 0, 0, 0, 11'h000), "wr_dtack");
    wait_dtack("write");
    tick(4);
    a = cyc;
    AS = 1'b1; LDS = 1'b1; RW = 1'b1; DRAM = 1'b1;
    push(a + 3, ev(1, 1, 1, 1, 1, 11'h000), "wr_release");

    // Aborted cycle at byte 0x2ABCDE: AS goes away before any data strobe.
    tick(6);
    n = cyc;
    ADDR = 22'h155E6F; RW = 1'b1; DRAM = 1'b0; AS = 1'b0;
    push(n + 3, ev(0, 1, 1, 1, 1, 11'h2AB), "abort_row");
    push(n + 4, ev(0, 1, 1, 1, 1, 11'h66F), "abort_col");
    push(n + 5, ev(1, 1, 1, 1, 1, 11'h66F), "abort_pre");
    tick(2);
    AS = 1'b1; DRAM = 1'b1;

    // First refresh: counter wraps 600 edges after reset release.
    push(r + 601, ev(1, 0, 0, 1, 1, 11'h66F), "ref_cas");
    push(r + 602, ev(0, 0, 0, 1, 1, 11'h66F), "ref_ras");
    push(r + 605, ev(1, 1, 1, 1, 1, 11'h66F), "ref_done");

    // Upper-byte read (byte 0x654320) synchronised on the edge the
    // second refresh request sets: refresh + precharge go first.
    while (cyc < r + 1198) @(negedge CLK);
    ADDR = 22'h32A190; RW = 1'b1; UDS = 1'b0; LDS = 1'b1; DRAM = 1'b0; AS = 1'b0;
    push(r + 1201,     ev(1, 0, 0, 1, 1, 11'h66F), "coll_ref_cas");
    push(r + 1202,     ev(0, 0, 0, 1, 1, 11'h66F), "coll_ref_ras");
    push(r + 1205,     ev(1, 1, 1, 1, 1, 11'h66F), "coll_ref_done");
    push(r + 1208,     ev(0, 1, 1, 1, 1, 11'h654), "coll_row");
    push(r + 1209,     ev(0, 1, 1, 1, 1, 11'h190), "coll_col");
    push(r + 1210,     ev(0, 0, 1, 1, 1, 11'h190), "coll_casu");
    push(r + 1211 + S, ev(0, 0, 1, 1, 0, 11'h190), "coll_dtack");
    wait_dtack("coll");

    // Reset while in ACK.
    e0 = cyc;
    RST = 1'b0; AS = 1'b1; UDS = 1'b1; LDS = 1'b1; DRAM = 1'b1;
    push(e0 + 1, ev(1, 1, 1, 1, 1, 11'h000), "reset_in_ack");
    tick(1);
    chk("reset_in_ack_state",   dut.state,   0);
    chk("reset_in_ack_refcnt",  dut.ref_cnt, 0);
    chk("reset_in_ack_pending", dut.ref_pend, 0);
    tick(1);
    RST = 1'b1;
    r2  = cyc;

    // Counter restarted from zero: next refresh 600 edges after release.
    push(r2 + 601, ev(1, 0, 0, 1, 1, 11'h000), "ref2_cas");
    push(r2 + 602, ev(0, 0, 0, 1, 1, 11'h000), "ref2_ras");
    push(r2 + 605, ev(1, 1, 1, 1, 1, 11'h000), "ref2_done");
    while (cyc < r2 + 612) @(negedge CLK);

    chk("events_drained", t_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
